// File: rtl/serial_add_arbiter.sv
// Round-robin bit-serial adder sharing one full-adder cell between two requesters.
// Define SERIAL_ADD_SUB_EN to add per-requester subtract (a - b) support.
//
// state | meaning
// IDLE  | arbitrate pending requests, accept one
// ADD   | one operand bit per cycle through the shared cell, LSB first
// DONE  | done pulse cycle, result/cout valid
module serial_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub0,
  input  logic             sub1,
`endif
  output logic [1:0]       grant,
  output logic             busy,
  output logic             done,
  output logic             owner,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] sum_sh;
  logic [WIDTH-1:0] sum_nxt;
  logic [WIDTH-1:0] b_sel;
  logic [CW-1:0]    cnt;
  logic             carry, last_owner;
  logic             accept, pick1, sel_sub, last_cnt;
  logic             sum_bit, cell_cout;

  assign accept = (state == IDLE) && (req0 || req1);
  // On a tie the requester that did not win last time goes first.
  assign pick1  = req1 && (!req0 || !last_owner);
`ifdef SERIAL_ADD_SUB_EN
  assign sel_sub = pick1 ? sub1 : sub0;
`else
  assign sel_sub = 1'b0;
`endif
  assign b_sel    = pick1 ? b1 : b0;
  assign last_cnt = (cnt == CW'(WIDTH - 1));

  assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
  assign cell_cout = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign sum_nxt   = {sum_bit, sum_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = ADD;
      ADD:     if (last_cnt) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      sum_sh     <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      last_owner <= 1'b1;
      grant      <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      owner      <= 1'b0;
      result     <= '0;
      cout       <= 1'b0;
    end else begin
      grant <= 2'b00;
      done  <= 1'b0;
      if (accept) begin
        a_sh       <= pick1 ? a1 : a0;
        // Subtraction is a + ~b + 1: invert b here, the +1 rides in on carry.
        b_sh       <= sel_sub ? ~b_sel : b_sel;
        cnt        <= '0;
        carry      <= sel_sub;
        owner      <= pick1;
        last_owner <= pick1;
        grant      <= pick1 ? 2'b10 : 2'b01;
        busy       <= 1'b1;
      end
      if (state == ADD) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        sum_sh <= sum_nxt[WIDTH-1:1];
        carry  <= cell_cout;
        cnt    <= cnt + CW'(1);
        if (last_cnt) begin
          done   <= 1'b1;
          result <= sum_nxt;
          cout   <= cell_cout;
        end
      end
      if (state == DONE) busy <= 1'b0;
    end
  end

endmodule
